// File: rtl/jt900h_blkmov_if.sv
// Memory bus between the block-move sequencer (master) and the memory system (slave).
interface jt900h_blkmov_if #(
  parameter int unsigned AW = 24
);
  logic [AW-1:0] bus_addr;
  logic          bus_rd;
  logic          bus_wr;
  logic [15:0]   bus_dout;
  logic [15:0]   bus_din;
  logic          bus_ack;

  modport master (
    output bus_addr, bus_rd, bus_wr, bus_dout,
    input  bus_din, bus_ack
  );

  modport slave (
    input  bus_addr, bus_rd, bus_wr, bus_dout,
    output bus_din, bus_ack
  );
endinterface

// File: rtl/jt900h_blkmov.sv
// TLCS-900H block transfer / block compare sequencer (LDI/LDIR/LDD/LDDR, CPI/CPIR/CPD/CPDR).
// Owns the memory bus for one iteration or a whole repeat, returns XDE/XHL/BC and flags.
// Optional feature macro: JT900H_BLKCMP_EN enables the CPx family; when undefined a CPx
// start completes immediately with no bus access and flags = {7'b0, c_in}.
module jt900h_blkmov #(
  parameter int unsigned AW = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic                   start,
  input  logic [2:0]             op,       // {cmp, dec, rep}
  input  logic                   word,
  input  logic [31:0]            xde_in,
  input  logic [31:0]            xhl_in,
  input  logic [15:0]            bc_in,
  input  logic [15:0]            acc,
  input  logic                   c_in,
  input  logic                   int_req,
  jt900h_blkmov_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   again,
  output logic [31:0]            xde,
  output logic [31:0]            xhl,
  output logic [15:0]            bc,
  output logic [7:0]             flags
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    UPD,
    FIN
  } state_t;

  state_t state, state_nx;

  logic        word_q;
  logic        dec_q;
  logic        rep_q;
  logic        cmp_q;
  logic        again_q;
  logic [15:0] data_q;

  logic [31:0] step;
  logic [31:0] xhl_nx;
  logic [31:0] xde_nx;
  logic [15:0] bc_nx;
  logic        v_nx;
  logic        hit;
  logic        more;
  logic [7:0]  flags_nx;

`ifdef JT900H_BLKCMP_EN
  logic [15:0] diff;
  logic        cmp_z;
`else
  logic        unused_acc;
  assign unused_acc = ^acc;
  assign cmp_q      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (cen) begin
      state <= state_nx;
    end
  end

  // Element step, pointer/count update and flag computation used in UPD
  always_comb begin
    step     = word_q ? 32'd2 : 32'd1;
    xhl_nx   = dec_q ? (xhl - step) : (xhl + step);
    xde_nx   = dec_q ? (xde - step) : (xde + step);
    bc_nx    = bc - 16'd1;
    v_nx     = (bc_nx != 16'd0);
    hit      = 1'b0;
    flags_nx = {flags[7], flags[6], 1'b0, 1'b0, 1'b0, v_nx, 1'b0, c_in};
`ifdef JT900H_BLKCMP_EN
    diff     = acc - data_q;
    cmp_z    = word_q ? (diff == 16'd0) : (diff[7:0] == 8'd0);
    if (cmp_q) begin
      hit      = cmp_z;
      flags_nx = {(word_q ? diff[15] : diff[7]), cmp_z, 1'b0,
                  (acc[3:0] < data_q[3:0]), 1'b0, v_nx, 1'b1, c_in};
    end
`endif
    // Another iteration is wanted; int_req decides between looping and yielding
    more     = rep_q && v_nx && !hit;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef JT900H_BLKCMP_EN
          state_nx = RD;
`else
          state_nx = op[2] ? FIN : RD;
`endif
        end
      end
      RD:      if (bus.bus_ack) state_nx = cmp_q ? UPD : WR;
      WR:      if (bus.bus_ack) state_nx = UPD;
      UPD:     state_nx = (more && !int_req) ? RD : FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers: operand latch at start, read data capture, writeback at UPD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xde     <= '0;
      xhl     <= '0;
      bc      <= '0;
      flags   <= '0;
      data_q  <= '0;
      word_q  <= 1'b0;
      dec_q   <= 1'b0;
      rep_q   <= 1'b0;
      again_q <= 1'b0;
`ifdef JT900H_BLKCMP_EN
      cmp_q   <= 1'b0;
`endif
    end else if (cen) begin
      case (state)
        IDLE: begin
          if (start) begin
            xde     <= xde_in;
            xhl     <= xhl_in;
            bc      <= bc_in;
            word_q  <= word;
            dec_q   <= op[1];
            rep_q   <= op[0];
            again_q <= 1'b0;
`ifdef JT900H_BLKCMP_EN
            cmp_q   <= op[2];
`else
            if (op[2]) flags <= {7'b0, c_in};
`endif
          end
        end
        RD: begin
          if (bus.bus_ack) data_q <= word_q ? bus.bus_din : {8'h00, bus.bus_din[7:0]};
        end
        UPD: begin
          xhl     <= xhl_nx;
          if (!cmp_q) xde <= xde_nx;
          bc      <= bc_nx;
          flags   <= flags_nx;
          again_q <= more && int_req;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state: strobes, address/data mux and status
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == FIN);
    again        = (state == FIN) && again_q;
    bus.bus_rd   = (state == RD);
    bus.bus_wr   = (state == WR);
    bus.bus_addr = '0;
    bus.bus_dout = '0;
    case (state)
      RD: bus.bus_addr = xhl[AW-1:0];
      WR: begin
        bus.bus_addr = xde[AW-1:0];
        bus.bus_dout = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jt900h_blkmov.sv
// Directed bench for jt900h_blkmov with a byte-addressed memory model and programmable wait states.
module tb_jt900h_blkmov;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        start;
  logic [2:0]  op;
  logic        word;
  logic [31:0] xde_in;
  logic [31:0] xhl_in;
  logic [15:0] bc_in;
  logic [15:0] acc;
  logic        c_in;
  logic        int_req;
  logic        busy;
  logic        done;
  logic        again;
  logic [31:0] xde;
  logic [31:0] xhl;
  logic [15:0] bc;
  logic [7:0]  flags;

  jt900h_blkmov_if #(.AW(24)) bus ();

  jt900h_blkmov #(.AW(24)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .start   (start),
    .op      (op),
    .word    (word),
    .xde_in  (xde_in),
    .xhl_in  (xhl_in),
    .bc_in   (bc_in),
    .acc     (acc),
    .c_in    (c_in),
    .int_req (int_req),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .again   (again),
    .xde     (xde),
    .xhl     (xhl),
    .bc      (bc),
    .flags   (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  int          ws;
  int          wcnt;
  int          rd_cnt;
  int          wr_cnt;
  int          strb_cnt;
  logic [23:0] last_waddr;
  logic [15:0] last_wdata;
  logic [15:0] a0;
  logic [15:0] a1;
  int          n_cmp;
  int          n_err;

  assign a0 = bus.bus_addr[15:0];
  assign a1 = bus.bus_addr[15:0] + 16'd1;

  // Slave side: ack after ws wait cycles, byte reads carry junk in the upper lane
  always @(negedge clk) begin
    if (bus.bus_rd || bus.bus_wr) begin
      strb_cnt <= strb_cnt + 1;
      if (wcnt >= ws) begin
        bus.bus_ack <= 1'b1;
        wcnt        <= 0;
        bus.bus_din <= word ? {mem[a1], mem[a0]} : {8'hEE, mem[a0]};
      end else begin
        bus.bus_ack <= 1'b0;
        wcnt        <= wcnt + 1;
      end
    end else begin
      bus.bus_ack <= 1'b0;
      bus.bus_din <= 16'h0000;
      wcnt        <= 0;
    end
  end

  // Completed accesses as the DUT sees them
  always @(posedge clk) begin
    if (rst_n && cen && bus.bus_ack) begin
      if (bus.bus_rd) rd_cnt <= rd_cnt + 1;
      if (bus.bus_wr) begin
        mem[a0] <= bus.bus_dout[7:0];
        if (word) mem[a1] <= bus.bus_dout[15:8];
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= bus.bus_addr;
        last_wdata <= bus.bus_dout;
      end
    end
  end

  task automatic launch(input logic [2:0] o, input logic w, input logic [31:0] de,
                        input logic [31:0] hl, input logic [15:0] cnt,
                        input logic [15:0] a, input logic ci);
    @(negedge clk);
    rd_cnt   = 0;
    wr_cnt   = 0;
    strb_cnt = 0;
    op       = o;
    word     = w;
    xde_in   = de;
    xhl_in   = hl;
    bc_in    = cnt;
    acc      = a;
    c_in     = ci;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, again, bus.bus_rd, bus.bus_wr} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, again, bus.bus_rd, bus.bus_wr});
    end
    n_cmp++;
    if ({bus.bus_addr, bus.bus_dout, xde, xhl, bc, flags} !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h dout=%h xde=%h xhl=%h bc=%h flags=%h expected all zero",
               bus.bus_addr, bus.bus_dout, xde, xhl, bc, flags);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ldi;
    int n;
    mem[16'h0100] = 8'h5A;
    launch(3'b000, 1'b0, 32'h200, 32'h100, 16'd3, 16'h0, 1'b0);
    n = 1;
    wait_done(n);
    n_cmp++;
    if (n !== 4) begin n_err++; $display("FAIL ldi_latency: got %0d expected 4", n); end
    n_cmp++;
    if ({xhl, xde, bc} !== {32'h101, 32'h201, 16'd2}) begin
      n_err++; $display("FAIL ldi_regs: got xhl=%h xde=%h bc=%h expected 101 201 2", xhl, xde, bc);
    end
    n_cmp++;
    if ({flags, again} !== {8'h04, 1'b0}) begin
      n_err++; $display("FAIL ldi_flags: got flags=%h again=%b expected 04 0", flags, again);
    end
    n_cmp++;
    if ({wr_cnt, last_waddr, last_wdata} !== {32'd1, 24'h200, 16'h005A}) begin
      n_err++; $display("FAIL ldi_write: got n=%0d addr=%h data=%h expected 1 200 005a",
                        wr_cnt, last_waddr, last_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL ldi_idle: got busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_ldir_word;
    int n;
    logic ok;
    for (int i = 0; i < 8; i++) mem[16'h1000 + 16'(i)] = 8'h11 + 8'(i);
    launch(3'b001, 1'b1, 32'h2000, 32'h1000, 16'd4, 16'h0, 1'b1);
    n = 1;
    repeat (4) begin @(negedge clk); n++; end
    // a start while busy must not disturb the operation
    xhl_in = 32'hDEAD;
    start  = 1'b1;
    @(negedge clk);
    n++;
    start  = 1'b0;
    wait_done(n);
    n_cmp++;
    if (n !== 13) begin n_err++; $display("FAIL ldir_latency: got %0d expected 13", n); end
    n_cmp++;
    if ({xhl, xde, bc} !== {32'h1008, 32'h2008, 16'd0}) begin
      n_err++; $display("FAIL ldir_regs: got xhl=%h xde=%h bc=%h expected 1008 2008 0", xhl, xde, bc);
    end
    n_cmp++;
    if ({flags, again} !== {8'h01, 1'b0}) begin
      n_err++; $display("FAIL ldir_flags: got flags=%h again=%b expected 01 0", flags, again);
    end
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (mem[16'h2000 + 16'(i)] !== 8'h11 + 8'(i)) ok = 1'b0;
    n_cmp++;
    if ({ok, rd_cnt, wr_cnt, last_wdata} !== {1'b1, 32'd4, 32'd4, 16'h1817}) begin
      n_err++; $display("FAIL ldir_copy: got ok=%b rd=%0d wr=%0d last=%h expected 1 4 4 1817",
                        ok, rd_cnt, wr_cnt, last_wdata);
    end
  endtask

  task automatic test_lddr_int;
    int n;
    mem[16'h3010] = 8'h9A;
    mem[16'h300F] = 8'h8B;
    ws = 2;
    launch(3'b011, 1'b0, 32'h4010, 32'h3010, 16'd5, 16'h0, 1'b0);
    n = 1;
    while (!done && n < 200) begin
      if (bus.bus_wr && wr_cnt == 1) int_req = 1'b1;
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n !== 15) begin n_err++; $display("FAIL lddr_latency: got %0d expected 15", n); end
    n_cmp++;
    if (again !== 1'b1) begin n_err++; $display("FAIL lddr_again: got %b expected 1", again); end
    n_cmp++;
    if ({xhl, xde, bc, flags} !== {32'h300E, 32'h400E, 16'd3, 8'h04}) begin
      n_err++; $display("FAIL lddr_regs: got xhl=%h xde=%h bc=%h flags=%h expected 300e 400e 3 04",
                        xhl, xde, bc, flags);
    end
    n_cmp++;
    if ({wr_cnt, mem[16'h4010], mem[16'h400F]} !== {32'd2, 8'h9A, 8'h8B}) begin
      n_err++; $display("FAIL lddr_copy: got wr=%0d %h %h expected 2 9a 8b",
                        wr_cnt, mem[16'h4010], mem[16'h400F]);
    end
    int_req = 1'b0;
    ws = 0;
    @(negedge clk);
  endtask

  task automatic test_cen_wrap;
    int n;
    logic froze;
    mem[16'h0800] = 8'hA5;
    launch(3'b000, 1'b0, 32'h900, 32'h800, 16'd0, 16'h0, 1'b0);
    n = 1;
    cen = 1'b0;
    froze = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n++;
      if (bus.bus_rd !== 1'b1 || bus.bus_addr !== 24'h800 || busy !== 1'b1) froze = 1'b0;
    end
    n_cmp++;
    if ({froze, rd_cnt} !== {1'b1, 32'd0}) begin
      n_err++; $display("FAIL cen_freeze: got held=%b reads=%0d expected 1 0", froze, rd_cnt);
    end
    cen = 1'b1;
    wait_done(n);
    n_cmp++;
    if (n !== 7) begin n_err++; $display("FAIL cen_latency: got %0d expected 7", n); end
    n_cmp++;
    if ({xhl, xde, bc, flags, mem[16'h0900]} !== {32'h801, 32'h901, 16'hFFFF, 8'h04, 8'hA5}) begin
      n_err++; $display("FAIL bc_wrap: got xhl=%h xde=%h bc=%h flags=%h m=%h expected 801 901 ffff 04 a5",
                        xhl, xde, bc, flags, mem[16'h0900]);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    launch(3'b001, 1'b0, 32'hB00, 32'hA00, 16'd8, 16'h0, 1'b0);
    n = 1;
    while (!bus.bus_wr && n < 20) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, again, bus.bus_rd, bus.bus_wr, bus.bus_addr, bus.bus_dout, xde, xhl, bc, flags} !== '0) begin
      n_err++; $display("FAIL reset_mid: got busy=%b wr=%b addr=%h xde=%h xhl=%h bc=%h flags=%h expected all zero",
                        busy, bus.bus_wr, bus.bus_addr, xde, xhl, bc, flags);
    end
    n_cmp++;
    if (wr_cnt !== 0) begin n_err++; $display("FAIL reset_mid_wr: got %0d writes expected 0", wr_cnt); end
    rst_n = 1'b1;
    launch(3'b000, 1'b0, 32'h200, 32'h100, 16'd3, 16'h0, 1'b0);
    n = 1;
    wait_done(n);
    n_cmp++;
    if ({n, xhl, xde, bc, flags} !== {32'd4, 32'h101, 32'h201, 16'd2, 8'h04}) begin
      n_err++; $display("FAIL reset_rerun: got n=%0d xhl=%h xde=%h bc=%h flags=%h expected 4 101 201 2 04",
                        n, xhl, xde, bc, flags);
    end
  endtask

`ifdef JT900H_BLKCMP_EN
  task automatic test_cpir;
    int n;
    mem[16'h0700] = 8'h11;
    mem[16'h0701] = 8'h22;
    mem[16'h0702] = 8'h33;
    launch(3'b101, 1'b0, 32'hC00, 32'h700, 16'd10, 16'h0033, 1'b0);
    n = 1;
    wait_done(n);
    n_cmp++;
    if ({n, rd_cnt, wr_cnt} !== {32'd7, 32'd3, 32'd0}) begin
      n_err++; $display("FAIL cpir_timing: got n=%0d rd=%0d wr=%0d expected 7 3 0", n, rd_cnt, wr_cnt);
    end
    n_cmp++;
    if ({xhl, xde, bc, flags, again} !== {32'h703, 32'hC00, 16'd7, 8'h46, 1'b0}) begin
      n_err++; $display("FAIL cpir_regs: got xhl=%h xde=%h bc=%h flags=%h again=%b expected 703 c00 7 46 0",
                        xhl, xde, bc, flags, again);
    end
  endtask
`else
  task automatic test_cpi_off;
    int n;
    launch(3'b100, 1'b0, 32'h600, 32'h500, 16'd7, 16'h0033, 1'b1);
    n = 1;
    wait_done(n);
    n_cmp++;
    if ({n, strb_cnt} !== {32'd1, 32'd0}) begin
      n_err++; $display("FAIL cpi_off_timing: got n=%0d strobes=%0d expected 1 0", n, strb_cnt);
    end
    n_cmp++;
    if ({xhl, xde, bc, flags, again} !== {32'h500, 32'h600, 16'd7, 8'h01, 1'b0}) begin
      n_err++; $display("FAIL cpi_off_regs: got xhl=%h xde=%h bc=%h flags=%h again=%b expected 500 600 7 01 0",
                        xhl, xde, bc, flags, again);
    end
  endtask
`endif

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    ws       = 0;
    wcnt     = 0;
    rd_cnt   = 0;
    wr_cnt   = 0;
    strb_cnt = 0;
    cen      = 1'b1;
    start    = 1'b0;
    op       = 3'b000;
    word     = 1'b0;
    xde_in   = '0;
    xhl_in   = '0;
    bc_in    = '0;
    acc      = '0;
    c_in     = 1'b0;
    int_req  = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset;
    test_ldi;
    test_ldir_word;
    test_lddr_int;
    test_cen_wrap;
    test_reset_mid;
`ifdef JT900H_BLKCMP_EN
    test_cpir;
`else
    test_cpi_off;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
